// File: rtl/scs8hd_bist_pkg.sv
// ============================================================================
// Module  : scs8hd_bist_pkg
// Purpose : Shared types, truth-table and MISR constants for the 3-input cell BIST.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package scs8hd_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } bist_state_e;

    localparam logic [7:0] TRUTH_AND3 = 8'h80;
    localparam logic [7:0] MISR_POLY  = 8'h1D;

    function automatic logic [7:0] misr_next(input logic [7:0] sig, input logic x_bit);
        return {sig[6:0], 1'b0} ^ (sig[7] ? MISR_POLY : 8'h00) ^ {7'b0, x_bit};
    endfunction

endpackage

`default_nettype wire

// File: rtl/scs8hd_bist_misr.sv
// ============================================================================
// Module  : scs8hd_bist_misr
// Purpose : 8-bit signature register folding one observed cell output per step.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module scs8hd_bist_misr
    import scs8hd_bist_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       step_i,
    input  logic       x_i,
    output logic [7:0] sig_o
);

    logic [7:0] sig_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sig_q <= 8'h00;
        end else if (clear_i) begin
            sig_q <= 8'h00;
        end else if (step_i) begin
            sig_q <= misr_next(sig_q, x_i);
        end
    end

    assign sig_o = sig_q;

endmodule

`default_nettype wire

// File: rtl/scs8hd_and3_bist_ctrl.sv
// ============================================================================
// Module  : scs8hd_and3_bist_ctrl
// Purpose : Exhaustive-vector BIST sequencer for a 3-input standard cell.
//           Optional MISR signature output enabled by SCS8HD_BIST_SIGNATURE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module scs8hd_and3_bist_ctrl
    import scs8hd_bist_pkg::*;
#(
    parameter int         SETTLE_CYC = 2,
    parameter logic [7:0] TRUTH      = TRUTH_AND3,
    parameter int         ERR_W      = 8,
    parameter int         LOOP_W     = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [LOOP_W-1:0] LOOPS,
    input  logic              DUT_X,
    output logic              DUT_A,
    output logic              DUT_B,
    output logic              DUT_C,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic [ERR_W-1:0]  ERR_CNT,
    output logic [2:0]        FAIL_VEC
`ifdef SCS8HD_BIST_SIGNATURE_EN
    ,
    output logic [7:0]        SIG
`endif
);

    localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [ERR_W-1:0]  ERR_ONE     = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [LOOP_W-1:0] LOOP_ONE    = {{(LOOP_W-1){1'b0}}, 1'b1};

    bist_state_e       state_q;
    logic [2:0]        vec_q;
    logic [3:0]        settle_q;
    logic [LOOP_W-1:0] loop_q;
    logic [LOOP_W-1:0] loops_q;
    logic [2:0]        abc_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [ERR_W-1:0]  err_q;
    logic [2:0]        fail_vec_q;
    logic              seen_fail_q;

    logic              mismatch_d;
    logic [ERR_W-1:0]  err_d;

    // Next error count is needed on the last SAMPLE edge to resolve PASS.
    assign mismatch_d = (DUT_X != TRUTH[vec_q]);
    assign err_d      = (mismatch_d && (err_q != {ERR_W{1'b1}})) ? (err_q + ERR_ONE) : err_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            vec_q       <= 3'd0;
            settle_q    <= 4'd0;
            loop_q      <= '0;
            loops_q     <= '0;
            abc_q       <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            fail_vec_q  <= 3'd0;
            seen_fail_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        state_q     <= ST_APPLY;
                        busy_q      <= 1'b1;
                        vec_q       <= 3'd0;
                        abc_q       <= 3'd0;
                        settle_q    <= 4'd0;
                        loop_q      <= '0;
                        loops_q     <= LOOPS;
                        err_q       <= '0;
                        fail_vec_q  <= 3'd0;
                        pass_q      <= 1'b0;
                        seen_fail_q <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    if (settle_q == SETTLE_LAST) begin
                        settle_q <= 4'd0;
                        state_q  <= ST_SAMPLE;
                    end else begin
                        settle_q <= settle_q + 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    err_q <= err_d;
                    if (mismatch_d && !seen_fail_q) begin
                        fail_vec_q  <= vec_q;
                        seen_fail_q <= 1'b1;
                    end
                    if (vec_q != 3'd7) begin
                        vec_q   <= vec_q + 3'd1;
                        abc_q   <= vec_q + 3'd1;
                        state_q <= ST_APPLY;
                    end else if (loop_q < loops_q) begin
                        loop_q  <= loop_q + LOOP_ONE;
                        vec_q   <= 3'd0;
                        abc_q   <= 3'd0;
                        state_q <= ST_APPLY;
                    end else begin
                        state_q <= ST_FINISH;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    abc_q   <= 3'd0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign DUT_A    = abc_q[2];
    assign DUT_B    = abc_q[1];
    assign DUT_C    = abc_q[0];
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign PASS     = pass_q;
    assign ERR_CNT  = err_q;
    assign FAIL_VEC = fail_vec_q;

`ifdef SCS8HD_BIST_SIGNATURE_EN
    logic start_accept;
    assign start_accept = (state_q == ST_IDLE) && START;

    scs8hd_bist_misr u_misr (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .clear_i (start_accept),
        .step_i  (state_q == ST_SAMPLE),
        .x_i     (DUT_X),
        .sig_o   (SIG)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_scs8hd_and3_bist_ctrl.sv
// ============================================================================
// Module  : tb_scs8hd_and3_bist_ctrl
// Purpose : Scoreboard bench for the cell BIST sequencer (SCS8HD_BIST_SIGNATURE_EN aware).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scs8hd_and3_bist_ctrl;
    import scs8hd_bist_pkg::*;

    localparam int SETTLE = 2;

    typedef struct {
        int         len;
        int         err;
        int         fv;
        int         pass;
        logic [7:0] sig;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] loops = 4'd0;
    int         mode = 0;
    logic       x, a, b, c, busy, done, pass;
    logic [7:0] err;
    logic [2:0] fv;

    logic       s_start = 1'b0;
    logic       s_a, s_b, s_c, s_busy, s_done, s_pass;
    logic [2:0] s_err;
    logic [2:0] s_fv;
`ifdef SCS8HD_BIST_SIGNATURE_EN
    logic [7:0] sig, s_sig;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done   = 0;
    int   cyc      = 0;
    int   s_cyc    = 0;
    exp_t sb[$];
    exp_t s_sb[$];
    exp_t mon_e;
    exp_t s_mon_e;

    always #5 clk = ~clk;

    // Ideal AND3 cell, or the output stuck at 0 / 1.
    assign x = (mode == 0) ? (a & b & c) : (mode == 2);

    scs8hd_and3_bist_ctrl #(.SETTLE_CYC(SETTLE)) u_dut (
        .CLK(clk), .RESET(rst), .START(start), .LOOPS(loops), .DUT_X(x),
        .DUT_A(a), .DUT_B(b), .DUT_C(c), .BUSY(busy), .DONE(done), .PASS(pass),
        .ERR_CNT(err), .FAIL_VEC(fv)
`ifdef SCS8HD_BIST_SIGNATURE_EN
        , .SIG(sig)
`endif
    );

    scs8hd_and3_bist_ctrl #(.SETTLE_CYC(SETTLE), .ERR_W(3)) u_sat (
        .CLK(clk), .RESET(rst), .START(s_start), .LOOPS(4'd3), .DUT_X(1'b1),
        .DUT_A(s_a), .DUT_B(s_b), .DUT_C(s_c), .BUSY(s_busy), .DONE(s_done), .PASS(s_pass),
        .ERR_CNT(s_err), .FAIL_VEC(s_fv)
`ifdef SCS8HD_BIST_SIGNATURE_EN
        , .SIG(s_sig)
`endif
    );

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [7:0] calc_sig(input int m, input int l);
        logic [7:0] s;
        logic       xb;
        s = 8'h00;
        for (int p = 0; p <= l; p++) begin
            for (int v = 0; v < 8; v++) begin
                xb = (m == 0) ? (v == 7) : (m == 2);
                s  = misr_next(s, xb);
            end
        end
        return s;
    endfunction

    // Main monitor: vector stepping every cycle, results on DONE.
    always @(negedge clk) begin
        if (rst) begin
            cyc = 0;
        end else if (busy) begin
            if (!done) chk("abc_step", {a, b, c}, (cyc / (SETTLE + 1)) % 8);
            if (done) begin
                n_done++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("busy_len", cyc + 1, mon_e.len);
                    chk("err_cnt", int'(err), mon_e.err);
                    chk("fail_vec", int'(fv), mon_e.fv);
                    chk("pass", int'(pass), mon_e.pass);
`ifdef SCS8HD_BIST_SIGNATURE_EN
                    chk("sig", int'(sig), int'(mon_e.sig));
`endif
                end
                cyc = 0;
            end else begin
                cyc++;
            end
        end else begin
            cyc = 0;
        end
    end

    // Saturation-instance monitor.
    always @(negedge clk) begin
        if (rst || !s_busy) begin
            s_cyc = 0;
        end else if (s_done) begin
            if (s_sb.size() == 0) begin
                chk("sat_unexpected_done", 1, 0);
            end else begin
                s_mon_e = s_sb.pop_front();
                chk("sat_busy_len", s_cyc + 1, s_mon_e.len);
                chk("sat_err_cnt", int'(s_err), s_mon_e.err);
                chk("sat_fail_vec", int'(s_fv), s_mon_e.fv);
                chk("sat_pass", int'(s_pass), s_mon_e.pass);
`ifdef SCS8HD_BIST_SIGNATURE_EN
                chk("sat_sig", int'(s_sig), int'(s_mon_e.sig));
`endif
            end
            s_cyc = 0;
        end else begin
            s_cyc++;
        end
    end

    task automatic issue(input int m, input int l, input int len, input int e_err,
                         input int e_fv, input int e_pass);
        exp_t e;
        e.len  = len;
        e.err  = e_err;
        e.fv   = e_fv;
        e.pass = e_pass;
        e.sig  = calc_sig(m, l);
        mode   = m;
        loops  = 4'(l);
        @(posedge clk); #1;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            chk("timeout_done", 0, 1);
            sb.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        exp_t se;
        int   done_snap;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", int'(err), 0);
        chk("rst_fv", int'(fv), 0);
        chk("rst_abc", {a, b, c}, 0);

        // Ideal cell, single pass; PASS must hold after DONE.
        issue(0, 0, 25, 0, 0, 1);
        drain();
        @(negedge clk);
        chk("pass_held", pass, 1);

        // Stuck-at-0: only vector 7 disagrees.
        issue(1, 0, 25, 1, 7, 0);
        drain();

        // Stuck-at-1, two passes: vectors 0..6 disagree each pass.
        issue(2, 1, 49, 14, 0, 0);
        drain();

        // Three passes; extra START and LOOPS change mid-run are ignored.
        issue(0, 2, 73, 0, 0, 1);
        repeat (20) @(posedge clk);
        #1 start = 1'b1; loops = 4'd0;
        @(posedge clk); #1 start = 1'b0;
        drain();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("no_requeue_busy", busy, 0);

        // Abort with RESET ten cycles into a run.
        mode = 2;
        loops = 4'd0;
        done_snap = n_done;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_pass", pass, 0);
        chk("abort_err", int'(err), 0);
        chk("abort_fv", int'(fv), 0);
        chk("abort_abc", {a, b, c}, 0);
        repeat (30) @(posedge clk);
        chk("abort_no_done", n_done, done_snap);

        // Clean run after the abort.
        issue(0, 0, 25, 0, 0, 1);
        drain();

        // Narrow counter: 28 mismatches saturate at 7.
        se.len  = 97;
        se.err  = 7;
        se.fv   = 0;
        se.pass = 0;
        se.sig  = calc_sig(2, 3);
        @(posedge clk); #1 s_start = 1'b1;
        s_sb.push_back(se);
        @(posedge clk); #1 s_start = 1'b0;
        for (int i = 0; i < 2000 && s_sb.size() != 0; i++) @(posedge clk);
        if (s_sb.size() != 0) begin
            chk("sat_timeout_done", 0, 1);
            s_sb.delete();
        end
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
